bin_bcd_conv: RTL and testbench
===============================

# bin_bcd_conv

Periodic binary-to-BCD converter feeding the 4-digit 7-segment driver. It samples a 14-bit unsigned measurement at a fixed display-update rate and converts it to four packed BCD digits using a sequential shift-add-3 (double dabble) loop. It presents the result on a held 16-bit bus with a one-cycle latch strobe that connects directly to the driver's data and latch inputs. Values above 9999 saturate and raise an overflow flag.

## Interface
- C_FCK, 48_000_000, clock frequency in Hz
- C_FUPD, 10, update (sample) rate in Hz; C_DIV = C_FCK / C_FUPD must be ≥ 16
- CK_i  in  1  clock
- XARST_i  in  1  reset, asynchronous, active-low
- BIN_i  in  14  unsigned binary value; only sampled on an accepted tick
- BIN_VLD_i  in  1  BIN_i qualifier; tick ignored when low
- DAT_o  out  16  packed BCD, [15:12] thousands … [3:0] units; held between latches
- LATCH_o  out  1  one-cycle strobe, DAT_o/OVF_o new this cycle
- BUSY_o  out  1  high while converting
- OVF_o  out  1  last latched sample exceeded 9999

## Operation
- Divider: DIV_CTR counts 0..C_DIV-1 and wraps. TICK = (DIV_CTR == C_DIV-1). Width is ceil(log2(C_DIV)).
- FSM states: IDLE, CONV, DONE.
- IDLE: on TICK & BIN_VLD_i, go to CONV.
  - If BIN_i > 9999: load 9999 into BIN_SR, set OVF_PEND=1.
  - Else: load BIN_i, set OVF_PEND=0.
  - Clear BCD_SR (16 b) and load STEP=13.
- IDLE: on TICK & ~BIN_VLD_i, do nothing. DAT_o/OVF_o hold and no LATCH_o is issued.
- CONV: each cycle, every BCD_SR nibble ≥ 5 gets +3 (4-bit add, no carry out). Then {BCD_SR,BIN_SR} shifts left 1.
  - STEP decrements each cycle. When STEP==0, go to DONE.
  - Exactly 14 CONV cycles.
- DONE: DAT_o <= BCD_SR, OVF_o <= OVF_PEND, LATCH_o = 1 for this single cycle, then return to IDLE.
- BIN_i and BIN_VLD_i changes during CONV/DONE are ignored (captured copy only).
- TICK outside IDLE is ignored. This cannot occur when C_DIV ≥ 16; the bench checks it anyway.
- BUSY_o = (state != IDLE).

## Timing
- Reset values:
  - DIV_CTR = C_DIV-1, so the first TICK occurs in the first cycle after reset release.
  - state = IDLE.
  - DAT_o = 0x0000, LATCH_o = 0, BUSY_o = 0, OVF_o = 0.
  - BIN_SR, BCD_SR, STEP, OVF_PEND = 0.
- Latency: accepted TICK in cycle T → BUSY_o high T+1..T+15 → LATCH_o high and DAT_o valid in cycle T+15. DAT_o stays stable until the next LATCH_o.
- LATCH_o is registered (state==DONE decode, registered output). It is never high for two consecutive cycles.
- Reset asserted mid-conversion: all registers return to reset values immediately. No LATCH_o is generated for the aborted sample.
- The divider free-runs regardless of FSM state or BIN_VLD_i.

## Structure
- Package bin_bcd_pkg:
  - C_BIN_W=14, C_BCD_W=16, C_BCD_MAX=14'd9999, C_NIB=4.
  - State enum {IDLE, CONV, DONE}.
  - Function f_log2 (ceil) for the divider width.
- Sub-module bcd_add3_adj: combinational, 16-bit in/out, applies the per-nibble ≥5 → +3 correction. It is instantiated once in the CONV datapath.
- Top holds the divider, FSM, shift registers and output registers.

## Test plan
- C_DIV=20 for sim. BIN_i=1234, VLD=1 → LATCH_o 15 cycles after the first TICK, DAT_o=0x1234, OVF_o=0, BUSY_o high for exactly 14+1 cycles.
- BIN_i=0, then 9999 on successive ticks → DAT_o=0x0000 then 0x9999, OVF_o=0 both times. Also check 10 → 0x0010.
- BIN_i=12000 (and 16383) → DAT_o=0x9999, OVF_o=1. Next sample 42 → DAT_o=0x0042, OVF_o=0.
- BIN_VLD_i=0 at a TICK after a latched 0x0555 → no LATCH_o and no BUSY_o for that period; DAT_o stays 0x0555.
- BIN_i changes from 1234 to 4321 at CONV cycle 5 → latched DAT_o=0x1234.
- XARST_i pulsed low at CONV cycle 7 → DAT_o=0x0000, BUSY_o=0, no LATCH_o. The first TICK follows reset release and a full conversion completes normally.
- Across every test, assert that LATCH_o is only ever one cycle wide and that exhaustive random BIN_i in 0..9999 matches a reference decimal model.

Source files
------------

// File: rtl/bin_bcd_conv_pkg.sv
// Shared types, widths and helpers for the binary-to-BCD display converter.
package bin_bcd_pkg;

  localparam int C_BIN_W = 14;
  localparam int C_BCD_W = 16;
  localparam int C_NIB   = 4;
  localparam logic [C_BIN_W-1:0] C_BCD_MAX = 14'd9999;

  // IDLE: waiting for an accepted tick
  // CONV: shift-add-3 loop, one input bit per cycle
  // DONE: result latched onto the output bus, strobe high
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2, used to size the update-rate divider.
  function automatic int f_log2(input int v);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/bin_bcd_conv_if.sv
// Sample-in / BCD-out bundle between the measurement source, the converter
// and the 7-segment driver.
interface bin_bcd_conv_if;
  import bin_bcd_pkg::*;

  logic [C_BIN_W-1:0] BIN_i;
  logic               BIN_VLD_i;
  logic [C_BCD_W-1:0] DAT_o;
  logic               LATCH_o;
  logic               BUSY_o;
  logic               OVF_o;

  modport master (
    output BIN_i, BIN_VLD_i,
    input  DAT_o, LATCH_o, BUSY_o, OVF_o
  );

  modport slave (
    input  BIN_i, BIN_VLD_i,
    output DAT_o, LATCH_o, BUSY_o, OVF_o
  );

endinterface

// File: rtl/bin_bcd_conv_add3_adj.sv
// Per-nibble double-dabble correction: any BCD digit of 5 or more gets +3
// so the following left shift carries correctly into the next decade.
module bcd_add3_adj
  import bin_bcd_pkg::*;
(
  input  logic [C_BCD_W-1:0] bcd_in,
  output logic [C_BCD_W-1:0] bcd_out
);

  // Nibbles are independent; the 4-bit add cannot overflow for legal digits.
  always_comb begin
    bcd_out = bcd_in;
    for (int i = 0; i < C_BCD_W / C_NIB; i++) begin
      if (bcd_in[i*C_NIB +: C_NIB] >= 4'd5) begin
        bcd_out[i*C_NIB +: C_NIB] = bcd_in[i*C_NIB +: C_NIB] + 4'd3;
      end
    end
  end

endmodule

// File: rtl/bin_bcd_conv.sv
// Periodic binary-to-BCD converter. A free-running divider produces the
// display-update tick; each accepted tick captures one sample, converts it
// over 14 shift-add-3 cycles and presents the result with a one-cycle strobe.
//
// state | meaning
// IDLE  | waiting for tick with valid sample
// CONV  | one shift-add-3 iteration per cycle, STEP counts down 13..0
// DONE  | LATCH_o high, DAT_o/OVF_o freshly updated
module bin_bcd_conv
  import bin_bcd_pkg::*;
#(
  parameter int C_FCK  = 48_000_000,
  parameter int C_FUPD = 10
) (
  input  logic           CK_i,
  input  logic           XARST_i,
  bin_bcd_conv_if.slave  bus
);

  localparam int C_DIV   = C_FCK / C_FUPD;
  localparam int C_DIV_W = f_log2(C_DIV);
  localparam logic [C_DIV_W-1:0] C_DIV_LAST  = C_DIV_W'(C_DIV - 1);
  localparam logic [3:0]         C_STEP_INIT = 4'(C_BIN_W - 1);

  logic [C_DIV_W-1:0] div_ctr;
  logic               tick;

  state_t             state;
  logic [C_BIN_W-1:0] bin_sr;
  logic [C_BCD_W-1:0] bcd_sr;
  logic [C_BCD_W-1:0] bcd_adj;
  logic [C_BCD_W-1:0] bcd_nxt;
  logic [3:0]         step;
  logic               ovf_pend;

  logic [C_BCD_W-1:0] dat_q;
  logic               latch_q;
  logic               ovf_q;

  // Divider resets to its last count so the first tick lands right after reset.
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      div_ctr <= C_DIV_LAST;
    end else if (div_ctr == C_DIV_LAST) begin
      div_ctr <= '0;
    end else begin
      div_ctr <= div_ctr + 1'b1;
    end
  end

  assign tick = (div_ctr == C_DIV_LAST);

  bcd_add3_adj u_add3 (
    .bcd_in  (bcd_sr),
    .bcd_out (bcd_adj)
  );

  // Corrected BCD shifted left with the next binary MSB entering at bit 0.
  assign bcd_nxt = {bcd_adj[C_BCD_W-2:0], bin_sr[C_BIN_W-1]};

  // Sequencer and datapath; the final iteration's result goes straight to the
  // output register so DAT_o and LATCH_o appear together in the DONE cycle.
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      state    <= IDLE;
      bin_sr   <= '0;
      bcd_sr   <= '0;
      step     <= '0;
      ovf_pend <= 1'b0;
      dat_q    <= '0;
      latch_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      latch_q <= 1'b0;
      case (state)
        IDLE: begin
          if (tick && bus.BIN_VLD_i) begin
            state  <= CONV;
            bcd_sr <= '0;
            step   <= C_STEP_INIT;
            if (bus.BIN_i > C_BCD_MAX) begin
              bin_sr   <= C_BCD_MAX;
              ovf_pend <= 1'b1;
            end else begin
              bin_sr   <= bus.BIN_i;
              ovf_pend <= 1'b0;
            end
          end
        end
        CONV: begin
          bcd_sr <= bcd_nxt;
          bin_sr <= {bin_sr[C_BIN_W-2:0], 1'b0};
          step   <= step - 1'b1;
          if (step == 4'd0) begin
            state   <= DONE;
            dat_q   <= bcd_nxt;
            ovf_q   <= ovf_pend;
            latch_q <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.DAT_o   = dat_q;
  assign bus.LATCH_o = latch_q;
  assign bus.OVF_o   = ovf_q;
  assign bus.BUSY_o  = (state != IDLE);

endmodule

// File: tb/tb_bin_bcd_conv.sv
// Directed and randomised checks of the binary-to-BCD converter with a
// 20-cycle update period.
module tb_bin_bcd_conv;
  import bin_bcd_pkg::*;

  logic ck = 1'b0;
  logic xarst = 1'b0;

  always #5 ck = ~ck;

  bin_bcd_conv_if bus ();

  bin_bcd_conv #(
    .C_FCK  (200),
    .C_FUPD (10)
  ) dut (
    .CK_i    (ck),
    .XARST_i (xarst),
    .bus     (bus)
  );

  typedef struct {
    logic [13:0] bin;
    logic [15:0] dat;
    logic        ovf;
  } vec_t;

  vec_t vecs [8];

  int   n_cmp = 0;
  int   n_err = 0;
  logic prev_latch = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock; samples at the falling edge and polices the strobe width.
  task automatic step();
    @(negedge ck);
    if (bus.LATCH_o === 1'b1) begin
      n_cmp++;
      if (prev_latch) begin
        n_err++;
        $display("FAIL latch_width: LATCH_o high two cycles in a row (t=%0t)", $time);
      end
    end
    prev_latch = bus.LATCH_o;
  endtask

  task automatic wait_latch(output int n, output int nbusy);
    n = 0;
    nbusy = 0;
    do begin
      step();
      n++;
      if (bus.BUSY_o) nbusy++;
    end while (bus.LATCH_o !== 1'b1 && n < 60);
    if (bus.LATCH_o !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL latch_timeout: no LATCH_o within %0d cycles", n);
    end
  endtask

  task automatic wait_busy();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (bus.BUSY_o !== 1'b1 && n < 40);
    if (bus.BUSY_o !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL busy_timeout: BUSY_o not seen within %0d cycles", n);
    end
  endtask

  function automatic logic [15:0] ref_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  initial begin
    int n, nb, nl;
    int v;

    vecs[0] = '{14'd0,     16'h0000, 1'b0};
    vecs[1] = '{14'd9999,  16'h9999, 1'b0};
    vecs[2] = '{14'd10,    16'h0010, 1'b0};
    vecs[3] = '{14'd12000, 16'h9999, 1'b1};
    vecs[4] = '{14'd16383, 16'h9999, 1'b1};
    vecs[5] = '{14'd42,    16'h0042, 1'b0};
    vecs[6] = '{14'd5678,  16'h5678, 1'b0};
    vecs[7] = '{14'd555,   16'h0555, 1'b0};

    bus.BIN_i     = 14'd1234;
    bus.BIN_VLD_i = 1'b1;

    repeat (3) step();
    chk("rst_dat",   bus.DAT_o, 16'h0000);
    chk("rst_latch", 16'(bus.LATCH_o), 16'd0);
    chk("rst_busy",  16'(bus.BUSY_o), 16'd0);
    chk("rst_ovf",   16'(bus.OVF_o), 16'd0);

    // First tick right after release; latch 15 cycles later.
    xarst = 1'b1;
    wait_latch(n, nb);
    chk("first_latency", 16'(n), 16'd15);
    chk("first_busy",    16'(nb), 16'd15);
    chk("first_dat",     bus.DAT_o, 16'h1234);
    chk("first_ovf",     16'(bus.OVF_o), 16'd0);

    for (int i = 0; i < 8; i++) begin
      bus.BIN_i = vecs[i].bin;
      wait_latch(n, nb);
      chk("vec_period", 16'(n), 16'd20);
      chk("vec_busy",   16'(nb), 16'd15);
      chk("vec_dat",    bus.DAT_o, vecs[i].dat);
      chk("vec_ovf",    16'(bus.OVF_o), 16'(vecs[i].ovf));
    end

    // Invalid sample: ticks pass without conversion, output held.
    bus.BIN_VLD_i = 1'b0;
    bus.BIN_i     = 14'd3;
    nl = 0;
    nb = 0;
    repeat (40) begin
      step();
      if (bus.LATCH_o) nl++;
      if (bus.BUSY_o) nb++;
    end
    chk("novld_latch", 16'(nl), 16'd0);
    chk("novld_busy",  16'(nb), 16'd0);
    chk("novld_dat",   bus.DAT_o, 16'h0555);

    // Input changes mid-conversion must not leak into the result.
    bus.BIN_i     = 14'd1234;
    bus.BIN_VLD_i = 1'b1;
    wait_busy();
    repeat (4) step();
    bus.BIN_i     = 14'd4321;
    bus.BIN_VLD_i = 1'b0;
    wait_latch(n, nb);
    chk("midchg_dat", bus.DAT_o, 16'h1234);
    chk("midchg_ovf", 16'(bus.OVF_o), 16'd0);

    bus.BIN_i     = 14'd12000;
    bus.BIN_VLD_i = 1'b1;
    wait_latch(n, nb);
    chk("pre_rst_ovf", 16'(bus.OVF_o), 16'd1);

    // Reset during CONV cycle 7 aborts the sample.
    bus.BIN_i = 14'd777;
    wait_busy();
    repeat (6) step();
    xarst = 1'b0;
    #1;
    chk("abort_dat",   bus.DAT_o, 16'h0000);
    chk("abort_busy",  16'(bus.BUSY_o), 16'd0);
    chk("abort_latch", 16'(bus.LATCH_o), 16'd0);
    chk("abort_ovf",   16'(bus.OVF_o), 16'd0);
    nl = 0;
    repeat (20) begin
      step();
      if (bus.LATCH_o) nl++;
    end
    chk("abort_nolatch", 16'(nl), 16'd0);
    xarst = 1'b1;
    wait_latch(n, nb);
    chk("post_rst_latency", 16'(n), 16'd15);
    chk("post_rst_dat",     bus.DAT_o, 16'h0777);

    for (int i = 0; i < 40; i++) begin
      v = int'($urandom_range(9999));
      bus.BIN_i = 14'(v);
      wait_latch(n, nb);
      chk("rand_dat", bus.DAT_o, ref_bcd(v));
      chk("rand_ovf", 16'(bus.OVF_o), 16'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
